// File: rtl/strided_bank_buffer.sv
// strided_bank_buffer: banked slice staging buffer with round-robin
// slice writes and a rotating multi-lane stride-1 slice replay.
module strided_bank_buffer #(
    parameter int N_BANK     = 3,
    parameter int N_LANE     = 3,
    parameter int DATA_WIDTH = 64,
    parameter int B_ADDR     = 9,
    parameter int LOG2_CPW   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [15:0]                  cfg_c,
    input  logic [15:0]                  cfg_k,
    input  logic                         cfg_mode,
    input  logic                         clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_start,
    input  logic [15:0]                  rd_passes,
    output logic                         rd_busy,
    output logic                         rd_valid,
    output logic [N_LANE*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_done,
    output logic                         err,
    output logic [15:0]                  slice_cnt
);
    localparam int BW = $clog2(N_BANK);
    localparam int PW = B_ADDR + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** B_ADDR);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_FULL} w_state_t;
    typedef enum logic {R_IDLE, R_RUN} r_state_t;

    w_state_t w_state, w_nxt;
    r_state_t r_state, r_nxt;

    logic [PW-1:0] eps_q;
    logic          mode_q;
    logic [PW-1:0] eps_new;
    logic [PW-1:0] eps_nxt;
    logic          idle;
    logic          cfg_ok;

    assign idle    = (w_state == W_IDLE) && (r_state == R_IDLE);
    assign cfg_ok  = cfg_we && idle;
    assign eps_new = PW'(32'(cfg_c >> LOG2_CPW) * 32'(cfg_k));
    assign eps_nxt = cfg_ok ? eps_new : eps_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            eps_q  <= '0;
            mode_q <= 1'b0;
        end else if (cfg_ok) begin
            eps_q  <= eps_new;
            mode_q <= cfg_mode;
        end
    end

    logic          wr_acc;
    logic [PW-1:0] wptr [N_BANK];
    logic [BW-1:0] wr_sel;
    logic [PW-1:0] ent;
    logic [PW-1:0] tgt_ptr;
    logic          slice_end;
    logic          tgt_fills;

    assign wr_acc    = wr_valid && wr_ready;
    assign slice_end = (ent == eps_q - PW'(1));
    assign tgt_fills = (tgt_ptr + PW'(1) == DEPTH);

    // Broadcast keeps all pointers in lockstep, so bank 0 stands for all.
    always_comb begin
        tgt_ptr = wptr[0];
        if (!mode_q) begin
            for (int b = 0; b < N_BANK; b++) begin
                if (wr_sel == BW'(b)) tgt_ptr = wptr[b];
            end
        end
    end

    always_comb begin
        w_nxt = w_state;
        unique case (w_state)
            W_IDLE: if (wr_acc) w_nxt = tgt_fills ? W_FULL : W_FILL;
            W_FILL: if (wr_acc && tgt_fills) w_nxt = W_FULL;
            default: w_nxt = w_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            w_state   <= W_IDLE;
            wr_ready  <= 1'b0;
            wr_sel    <= '0;
            ent       <= '0;
            slice_cnt <= '0;
            for (int b = 0; b < N_BANK; b++) wptr[b] <= '0;
        end else begin
            w_state  <= w_nxt;
            wr_ready <= (w_nxt != W_FULL) && (eps_nxt != '0);
            if (wr_acc) begin
                for (int b = 0; b < N_BANK; b++) begin
                    if (mode_q || wr_sel == BW'(b))
                        wptr[b] <= wptr[b] + PW'(1);
                end
                if (slice_end) begin
                    ent       <= '0;
                    slice_cnt <= slice_cnt + 16'd1;
                    if (!mode_q)
                        wr_sel <= (wr_sel == BW'(N_BANK - 1)) ? '0 : wr_sel + BW'(1);
                end else begin
                    ent <= ent + PW'(1);
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] bank_q  [N_BANK];
    logic [B_ADDR-1:0]     bank_ra [N_BANK];

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [2**B_ADDR];
        logic [DATA_WIDTH-1:0] q;
        logic                  we;
        assign we = wr_acc && (mode_q || wr_sel == BW'(b));
        always_ff @(posedge clk) begin
            if (we) mem[wptr[b][B_ADDR-1:0]] <= wr_data;
            q <= mem[bank_ra[b]];
        end
        assign bank_q[b] = q;
    end

    logic [BW-1:0]     lane_bank   [N_LANE];
    logic [BW-1:0]     lane_bank_d [N_LANE];
    logic [B_ADDR-1:0] lane_base   [N_LANE];
    logic [PW-1:0]     e_q;
    logic [15:0]       pass_left;
    logic              pass_end;
    logic              last;
    logic [16:0]       need;
    logic              rd_ok;
    logic              rd_rej;
    logic [B_ADDR-1:0] eps_lo;

    assign eps_lo   = eps_q[B_ADDR-1:0];
    assign pass_end = (r_state == R_RUN) && (e_q == eps_q - PW'(1));
    assign last     = pass_end && (pass_left == 16'd1);
    assign need     = mode_q ? {1'b0, rd_passes}
                             : {1'b0, rd_passes} + 17'(N_LANE - 1);
    assign rd_ok    = (rd_passes != 16'd0) && (eps_q != '0)
                      && ({1'b0, slice_cnt} >= need);
    assign rd_rej   = rd_start && (r_state == R_IDLE) && !rd_ok;
    assign rd_busy  = (r_state == R_RUN) || rd_valid;

    always_comb begin
        r_nxt = r_state;
        unique case (r_state)
            R_IDLE: if (rd_start && rd_ok) r_nxt = R_RUN;
            R_RUN:  if (last) r_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            bank_ra[b] = '0;
            for (int l = 0; l < N_LANE; l++) begin
                if (lane_bank[l] == BW'(b))
                    bank_ra[b] = lane_base[l] + e_q[B_ADDR-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int l = 0; l < N_LANE; l++) begin
            for (int b = 0; b < N_BANK; b++) begin
                if (lane_bank_d[l] == BW'(b))
                    rd_data[l*DATA_WIDTH +: DATA_WIDTH] = bank_q[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state   <= R_IDLE;
            rd_valid  <= 1'b0;
            rd_done   <= 1'b0;
            e_q       <= '0;
            pass_left <= '0;
            for (int l = 0; l < N_LANE; l++) begin
                lane_bank[l]   <= BW'(l);
                lane_bank_d[l] <= BW'(l);
                lane_base[l]   <= '0;
            end
        end else begin
            r_state  <= r_nxt;
            rd_valid <= (r_state == R_RUN);
            rd_done  <= last;
            if (r_state == R_IDLE && r_nxt == R_RUN) begin
                e_q       <= '0;
                pass_left <= rd_passes;
                for (int l = 0; l < N_LANE; l++) begin
                    lane_bank[l] <= BW'(l);
                    lane_base[l] <= '0;
                end
            end else if (r_state == R_RUN) begin
                for (int l = 0; l < N_LANE; l++)
                    lane_bank_d[l] <= lane_bank[l];
                if (pass_end) begin
                    e_q       <= '0;
                    pass_left <= pass_left - 16'd1;
                    // Lanes rotate one bank per pass; a wrap moves to the next row of slices.
                    for (int l = 0; l < N_LANE; l++) begin
                        if (mode_q) begin
                            lane_base[l] <= lane_base[l] + eps_lo;
                        end else if (lane_bank[l] == BW'(N_BANK - 1)) begin
                            lane_bank[l] <= '0;
                            lane_base[l] <= lane_base[l] + eps_lo;
                        end else begin
                            lane_bank[l] <= lane_bank[l] + BW'(1);
                        end
                    end
                end else begin
                    e_q <= e_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            err <= 1'b0;
        else if ((cfg_we && !idle) || rd_rej)
            err <= 1'b1;
    end
endmodule

// File: tb/tb_strided_bank_buffer.sv
// tb_strided_bank_buffer: directed scoreboard bench for the banked
// slice buffer (strided, broadcast, fill limit, reject and abort).
module tb_strided_bank_buffer;
    localparam int NB = 3;
    localparam int NL = 3;
    localparam int DW = 64;
    localparam int LW = NL * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [15:0]   cfg_c;
    logic [15:0]   cfg_k;
    logic          cfg_mode;
    logic          clr;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_start;
    logic [15:0]   rd_passes;
    logic          rd_busy;
    logic          rd_valid;
    logic [LW-1:0] rd_data;
    logic          rd_done;
    logic          err;
    logic [15:0]   slice_cnt;

    strided_bank_buffer #(
        .N_BANK(NB), .N_LANE(NL), .DATA_WIDTH(DW), .B_ADDR(9), .LOG2_CPW(6)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_c(cfg_c), .cfg_k(cfg_k),
        .cfg_mode(cfg_mode), .clr(clr), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_start(rd_start),
        .rd_passes(rd_passes), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_done(rd_done), .err(err),
        .slice_cnt(slice_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [LW-1:0] obs,
                         input logic [LW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] wv(input int tag, input int s, input int e);
        return {8'hC0, 8'(tag), 16'(s), 32'(e)};
    endfunction

    task automatic do_cfg(input int c, input int k, input bit m);
        cfg_we = 1'b1; cfg_c = 16'(c); cfg_k = 16'(k); cfg_mode = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic write_words(input int tag, input int first, input int n,
                               input int eps, output int cycles);
        int i;
        int cyc;
        logic acc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < n + 64) begin
            wr_valid = 1'b1;
            wr_data = wv(tag, (first + i) / eps, (first + i) % eps);
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        wr_valid = 1'b0;
        check("wr_words_accepted", LW'(i), LW'(n));
        cycles = cyc;
    endtask

    task automatic push_exp(input int tag, input int passes, input int eps,
                            input bit bcast);
        logic [LW-1:0] v;
        for (int p = 0; p < passes; p++) begin
            for (int e = 0; e < eps; e++) begin
                v = '0;
                for (int l = 0; l < NL; l++)
                    v[l*DW +: DW] = wv(tag, bcast ? p : p + l, e);
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic run_read(input int passes, input int eps,
                            input int abort_at, input int cfg_at);
        int nval;
        int limit;
        int k;
        bit done_seen;
        logic [LW-1:0] ev;
        rd_start = 1'b1;
        rd_passes = 16'(passes);
        @(posedge clk); #1;
        rd_start = 1'b0;
        nval = 0;
        done_seen = 1'b0;
        limit = (abort_at >= 0) ? abort_at + 1 : passes * eps + 10;
        k = 0;
        while (k < limit && !done_seen) begin
            if (k == cfg_at) begin
                cfg_we = 1'b1; cfg_c = 16'd64; cfg_k = 16'd4; cfg_mode = 1'b1;
            end
            if (k == abort_at) clr = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                check("rd_latency_gap", LW'(rd_valid), LW'(0));
                check("rd_busy_start", LW'(rd_busy), LW'(1));
            end
            if (cfg_at >= 0 && k == cfg_at + 1)
                check("cfg_busy_err", LW'(err), LW'(1));
            if (rd_valid) begin
                if (nval == 0) check("rd_first_valid", LW'(k), LW'(1));
                if (exp_q.size() == 0) begin
                    check("rd_extra_valid", LW'(1), LW'(0));
                end else begin
                    ev = exp_q.pop_front();
                    check("rd_data", rd_data, ev);
                    check("rd_done", LW'(rd_done), LW'(exp_q.size() == 0));
                end
                nval++;
                done_seen = rd_done;
                if (done_seen) check("rd_busy_on_done", LW'(rd_busy), LW'(1));
            end else if (nval > 0) begin
                check("rd_gap", LW'(rd_valid), LW'(1));
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            clr = 1'b0;
            k++;
        end
        if (abort_at >= 0) begin
            int hits;
            @(negedge clk);
            check("abort_valid", LW'(rd_valid), LW'(0));
            check("abort_busy", LW'(rd_busy), LW'(0));
            check("abort_err", LW'(err), LW'(0));
            hits = 0;
            for (int i = 0; i < 25; i++) begin
                if (rd_valid || rd_done) hits++;
                @(negedge clk);
            end
            check("abort_quiet", LW'(hits), LW'(0));
            check("abort_nval", LW'(nval), LW'(abort_at));
            exp_q.delete();
            @(posedge clk); #1;
        end else begin
            check("rd_timeout", LW'(done_seen), LW'(1));
            check("rd_valid_count", LW'(nval), LW'(passes * eps));
            @(negedge clk);
            check("rd_busy_after", LW'(rd_busy), LW'(0));
            check("rd_valid_after", LW'(rd_valid), LW'(0));
            @(posedge clk); #1;
        end
    endtask

    task automatic reject_read(input int passes);
        int hits;
        rd_start = 1'b1;
        rd_passes = 16'(passes);
        @(posedge clk); #1;
        rd_start = 1'b0;
        @(negedge clk);
        check("rej_err", LW'(err), LW'(1));
        check("rej_busy", LW'(rd_busy), LW'(0));
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            if (rd_valid) hits++;
            @(negedge clk);
        end
        check("rej_no_valid", LW'(hits), LW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int hits;
        rst = 1'b1; cfg_we = 1'b0; cfg_c = '0; cfg_k = '0; cfg_mode = 1'b0;
        clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_start = 1'b0;
        rd_passes = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_ready", LW'(wr_ready), LW'(0));
        check("rst_rd_busy", LW'(rd_busy), LW'(0));
        check("rst_rd_valid", LW'(rd_valid), LW'(0));
        check("rst_rd_done", LW'(rd_done), LW'(0));
        check("rst_err", LW'(err), LW'(0));
        check("rst_slice_cnt", LW'(slice_cnt), LW'(0));
        @(posedge clk); #1;

        // strided eps=18: three slices, one pass
        do_cfg(128, 9, 1'b0);
        write_words(1, 0, 54, 18, cyc);
        check("fill54_cycles", LW'(cyc), LW'(54));
        check("fill54_slices", LW'(slice_cnt), LW'(3));
        check("fill54_ready", LW'(wr_ready), LW'(1));
        push_exp(1, 1, 18, 1'b0);
        run_read(1, 18, -1, -1);

        // two more slices, three passes with bank wrap
        write_words(1, 54, 36, 18, cyc);
        check("fill90_slices", LW'(slice_cnt), LW'(5));
        push_exp(1, 3, 18, 1'b0);
        run_read(3, 18, -1, -1);
        reject_read(4);
        do_clr();
        check("clr_err", LW'(err), LW'(0));
        check("clr_slices", LW'(slice_cnt), LW'(0));

        // broadcast eps=4, two rows
        do_cfg(64, 4, 1'b1);
        write_words(3, 0, 8, 4, cyc);
        check("bc_slices", LW'(slice_cnt), LW'(2));
        push_exp(3, 2, 4, 1'b1);
        run_read(2, 4, -1, -1);

        // eps=512 fills bank 0 to depth
        do_clr();
        do_cfg(64, 512, 1'b0);
        write_words(4, 0, 512, 512, cyc);
        check("full_cycles", LW'(cyc), LW'(512));
        check("full_ready", LW'(wr_ready), LW'(0));
        check("full_slices", LW'(slice_cnt), LW'(1));
        wr_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_ready) hits++;
        end
        wr_valid = 1'b0;
        check("full_hold", LW'(hits), LW'(0));
        @(posedge clk); #1;
        do_clr();
        check("full_clr_slices", LW'(slice_cnt), LW'(0));
        @(posedge clk); #1;
        check("full_clr_ready", LW'(wr_ready), LW'(1));

        // abort mid-replay, with a config attempt while busy
        do_clr();
        do_cfg(128, 9, 1'b0);
        write_words(5, 0, 54, 18, cyc);
        push_exp(5, 1, 18, 1'b0);
        run_read(1, 18, 5, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
